module_keypad_reader: RTL and testbench

//  Receive side of the 4x4 keypad scan. The 2-bit column counter drives one keypad column per clk.

---
 rtl/module_keypad_reader.sv | 165 ++++++++++++++++
 tb/tb_module_keypad_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_keypad_reader.sv
// Keypad row reader: synchronises the row lines, debounces a single-key
// press against the column that was active when it was sampled, decodes it
// to a key value and holds the column scan (stop) until the key is released.
module module_keypad_reader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] col_sel,
  input  logic [3:0] row_in,
  output logic       stop,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    HELD,
    RELEASE
  } state_t;

  logic [3:0] row_sync [SYNC_STAGES];
  logic [1:0] col_dly  [SYNC_STAGES];
  logic [3:0] row_s;
  logic [1:0] col_s;

  logic           onehot;
  logic [1:0]     row_idx;

  state_t         state, state_n;
  logic [1:0]     r_l, r_n;
  logic [1:0]     c_l, c_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]     code_n;

  // Key value for a given row/column position on the keypad face.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'hE;
      4'b11_01: key_map = 4'h0;
      4'b11_10: key_map = 4'hF;
      default:  key_map = 4'hD;
    endcase
  endfunction

  // Synchroniser on the rows plus a matching delay line on the column so both stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        row_sync[i] <= 4'b0;
        col_dly[i]  <= 2'b0;
      end
    end else begin
      row_sync[0] <= row_in;
      col_dly[0]  <= col_sel;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        row_sync[i] <= row_sync[i-1];
        col_dly[i]  <= col_dly[i-1];
      end
    end
  end

  assign row_s = row_sync[SYNC_STAGES-1];
  assign col_s = col_dly[SYNC_STAGES-1];

  // Single-row detection and the position of that row; multi-row patterns are ghosts.
  always_comb begin
    onehot  = (row_s != 4'b0) && ((row_s & (row_s - 4'd1)) == 4'b0);
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_s[i]) row_idx = 2'(i);
    end
  end

  // Next-state logic; the debounce count saturates instead of wrapping.
  always_comb begin
    state_n = state;
    r_n     = r_l;
    c_n     = c_l;
    cnt_n   = cnt;
    code_n  = key_code;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    case (state)
      IDLE: begin
        if (onehot) begin
          r_n     = row_idx;
          c_n     = col_s;
          cnt_n   = CNT_ONE;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if ((row_s == (4'b0001 << r_l)) && (col_s == c_l)) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) state_n = PRESSED;
        end else begin
          state_n = IDLE;
        end
      end
      PRESSED: begin
        code_n  = key_map(r_l, c_l);
        state_n = HELD;
      end
      HELD: begin
        if (!row_s[r_l]) begin
          cnt_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (row_s[r_l]) begin
          state_n = HELD;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs; stop and key_held follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_l       <= 2'd0;
      c_l       <= 2'd0;
      cnt       <= '0;
      stop      <= 1'b0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      r_l       <= r_n;
      c_l       <= c_n;
      cnt       <= cnt_n;
      stop      <= (state_n != IDLE);
      key_code  <= code_n;
      key_valid <= (state == PRESSED);
      key_held  <= (state_n == HELD) || (state_n == RELEASE);
    end
  end

endmodule

// File: tb/tb_module_keypad_reader.sv
// Bench for the keypad reader: directed scenarios plus randomized key
// sessions, compared every cycle against a run-length reference model.
module tb_module_keypad_reader;

  localparam int DEB  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] col_sel = 2'd0;
  logic [3:0] row_in = 4'b0;
  logic       stop;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int tests = 0;
  int fails = 0;

  module_keypad_reader #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst(rst),
    .col_sel(col_sel),
    .row_in(row_in),
    .stop(stop),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad face, indexed by row*4 + column.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model: a key is accepted after DEB identical single-row samples on
  // one column, reported one cycle later, and released after DEB samples with its row low.
  logic [3:0] pipe_r [SYNC];
  logic [1:0] pipe_c [SYNC];
  int  press_run = 0;
  int  rel_run = 0;
  bit  pulse_now = 0;
  bit  down = 0;
  int  key_r = 0;
  int  key_c = 0;
  logic exp_stop = 0, exp_valid = 0, exp_held = 0;
  logic [3:0] exp_code = 4'h0;

  always @(posedge clk) begin
    logic [3:0] rs;
    logic [1:0] cs;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) begin
        pipe_r[i] = 4'b0;
        pipe_c[i] = 2'd0;
      end
      press_run = 0; rel_run = 0; pulse_now = 0; down = 0;
      exp_stop = 0; exp_valid = 0; exp_held = 0; exp_code = 4'h0;
    end else begin
      rs = pipe_r[SYNC-1];
      cs = pipe_c[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) begin
        pipe_r[i] = pipe_r[i-1];
        pipe_c[i] = pipe_c[i-1];
      end
      pipe_r[0] = row_in;
      pipe_c[0] = col_sel;
      exp_valid = 0;
      if (pulse_now) begin
        exp_valid = 1;
        exp_code  = kmap[key_r * 4 + key_c];
        pulse_now = 0;
        down      = 1;
        rel_run   = 0;
      end else if (down) begin
        if (rel_run == 0) begin
          if (!rs[key_r]) rel_run = 1;
        end else if (rs[key_r]) begin
          rel_run = 0;
        end else begin
          rel_run++;
          if (rel_run == DEB) begin
            down = 0;
            rel_run = 0;
          end
        end
      end else if (press_run == 0) begin
        if ($countones(rs) == 1) begin
          for (int i = 0; i < 4; i++) if (rs[i]) key_r = i;
          key_c = int'(cs);
          press_run = 1;
        end
      end else if (rs == (4'b0001 << key_r) && int'(cs) == key_c) begin
        press_run++;
        if (press_run == DEB) begin
          pulse_now = 1;
          press_run = 0;
        end
      end else begin
        press_run = 0;
      end
      exp_stop = (press_run > 0) || pulse_now || down;
      exp_held = down;
    end
  end

  // Drive one cycle of inputs away from the edge, then let the edge happen.
  task automatic apply_stimulus(input logic r, input logic [3:0] rows, input logic [1:0] col);
    @(negedge clk);
    rst = r;
    row_in = rows;
    col_sel = col;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 4'b0010, 2'd1);
      tests++;
      if ({stop, key_valid, key_held, key_code} !== 7'b0) begin
        fails++;
        $display("[TB] FAIL reset cyc %0d: stop/valid/held/code=%b/%b/%b/%h expected 0/0/0/0",
                 i, stop, key_valid, key_held, key_code);
      end
    end
  endtask

  task automatic test_press();
    int pulses = 0, pulse_cyc = -1, fall_cyc = -1;
    logic [3:0] code_seen = 4'h0;
    for (int i = 1; i <= 70; i++) begin
      apply_stimulus(1'b0, (i <= 40) ? 4'b0010 : 4'b0000, 2'd2);
      tests++;
      if ({stop, key_valid, key_held, key_code} !== {exp_stop, exp_valid, exp_held, exp_code}) begin
        fails++;
        $display("[TB] FAIL press cyc %0d: stop/valid/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                 i, stop, key_valid, key_held, key_code, exp_stop, exp_valid, exp_held, exp_code);
      end
      if (key_valid) begin pulses++; pulse_cyc = i; code_seen = key_code; end
      if (i > 40 && !key_held && fall_cyc < 0) fall_cyc = i - 40;
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("[TB] FAIL press_pulses: got %0d expected 1", pulses); end
    tests++;
    if (pulse_cyc !== 19) begin fails++; $display("[TB] FAIL press_latency: got %0d expected 19", pulse_cyc); end
    tests++;
    if (code_seen !== 4'h6) begin fails++; $display("[TB] FAIL press_code: got %h expected 6", code_seen); end
    tests++;
    if (fall_cyc !== 18) begin fails++; $display("[TB] FAIL release_time: got %0d expected 18", fall_cyc); end
  endtask

  task automatic test_bounce();
    int early = 0, pulses = 0;
    logic [3:0] code_seen = 4'h0;
    logic [3:0] rows;
    for (int i = 1; i <= 100; i++) begin
      if (i <= 30) rows = (((i - 1) / 5) % 2 == 0) ? 4'b0001 : 4'b0000;
      else rows = (i <= 70) ? 4'b0001 : 4'b0000;
      apply_stimulus(1'b0, rows, 2'd0);
      tests++;
      if ({stop, key_valid, key_held, key_code} !== {exp_stop, exp_valid, exp_held, exp_code}) begin
        fails++;
        $display("[TB] FAIL bounce cyc %0d: stop/valid/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                 i, stop, key_valid, key_held, key_code, exp_stop, exp_valid, exp_held, exp_code);
      end
      if (key_valid) begin
        pulses++;
        code_seen = key_code;
        if (i <= 32) early++;
      end
    end
    tests++;
    if (early !== 0) begin fails++; $display("[TB] FAIL bounce_early: got %0d pulses expected 0", early); end
    tests++;
    if (pulses !== 1) begin fails++; $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulses); end
    tests++;
    if (code_seen !== 4'h1) begin fails++; $display("[TB] FAIL bounce_code: got %h expected 1", code_seen); end
  endtask

  task automatic test_ghost();
    for (int i = 1; i <= 30; i++) begin
      apply_stimulus(1'b0, 4'b0101, 2'd1);
      tests++;
      if ({stop, key_valid, key_held} !== 3'b000) begin
        fails++;
        $display("[TB] FAIL ghost cyc %0d: stop/valid/held=%b/%b/%b expected 0/0/0",
                 i, stop, key_valid, key_held);
      end
    end
    apply_stimulus(1'b0, 4'b0000, 2'd1);
  endtask

  task automatic test_release_bounce();
    int pulses = 0, held_drop = 0;
    logic [3:0] rows;
    for (int i = 1; i <= 86; i++) begin
      rows = (i <= 30 || (i > 36 && i <= 56)) ? 4'b1000 : 4'b0000;
      apply_stimulus(1'b0, rows, 2'd3);
      tests++;
      if ({stop, key_valid, key_held, key_code} !== {exp_stop, exp_valid, exp_held, exp_code}) begin
        fails++;
        $display("[TB] FAIL rel_bounce cyc %0d: stop/valid/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                 i, stop, key_valid, key_held, key_code, exp_stop, exp_valid, exp_held, exp_code);
      end
      if (key_valid) pulses++;
      if (i > 30 && i <= 56 && !key_held) held_drop++;
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("[TB] FAIL rel_bounce_pulses: got %0d expected 1", pulses); end
    tests++;
    if (held_drop !== 0) begin fails++; $display("[TB] FAIL rel_bounce_held: low for %0d cycles expected 0", held_drop); end
    tests++;
    if (key_held !== 1'b0) begin fails++; $display("[TB] FAIL rel_bounce_final: key_held=%b expected 0", key_held); end
  endtask

  task automatic test_mid_reset();
    int pulses = 0, pulse_cyc = -1;
    logic [3:0] code_seen = 4'h0;
    for (int i = 1; i <= 25; i++) apply_stimulus(1'b0, 4'b1000, 2'd3);
    tests++;
    if (key_held !== 1'b1) begin fails++; $display("[TB] FAIL midrst_held: key_held=%b expected 1", key_held); end
    apply_stimulus(1'b1, 4'b1000, 2'd3);
    tests++;
    if ({stop, key_valid, key_held, key_code} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL midrst_clear: stop/valid/held/code=%b/%b/%b/%h expected 0/0/0/0",
               stop, key_valid, key_held, key_code);
    end
    for (int i = 1; i <= 60; i++) begin
      apply_stimulus(1'b0, (i <= 30) ? 4'b1000 : 4'b0000, 2'd3);
      tests++;
      if ({stop, key_valid, key_held, key_code} !== {exp_stop, exp_valid, exp_held, exp_code}) begin
        fails++;
        $display("[TB] FAIL midrst cyc %0d: stop/valid/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                 i, stop, key_valid, key_held, key_code, exp_stop, exp_valid, exp_held, exp_code);
      end
      if (key_valid) begin pulses++; pulse_cyc = i; code_seen = key_code; end
    end
    tests++;
    if (pulses !== 1 || pulse_cyc !== 19) begin
      fails++;
      $display("[TB] FAIL midrst_pulse: %0d pulses at cyc %0d expected 1 at 19", pulses, pulse_cyc);
    end
    tests++;
    if (code_seen !== 4'hD) begin fails++; $display("[TB] FAIL midrst_code: got %h expected D", code_seen); end
  endtask

  task automatic test_random();
    int r, c, n_bounce, n_hold, n_gap, extra;
    logic [3:0] rows;
    logic [1:0] col;
    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      n_gap = int'($urandom_range(12, 4));
      n_bounce = ($urandom % 2 == 0) ? 0 : int'($urandom_range(12, 3));
      n_hold = int'($urandom_range(40, 22));
      extra = int'($urandom_range(3, 0));
      for (int t = 0; t < n_gap + n_bounce + n_hold + 30; t++) begin
        col = 2'(c);
        if (t < n_gap) begin
          rows = ($urandom % 8 == 0) ? 4'(1 << $urandom_range(3, 0)) : 4'b0;
          col = 2'($urandom_range(3, 0));
        end else if (t < n_gap + n_bounce) begin
          rows = ($urandom % 2 == 0) ? 4'(1 << r) : 4'b0;
          if ($urandom % 4 == 0) col = 2'($urandom_range(3, 0));
        end else if (t < n_gap + n_bounce + n_hold) begin
          rows = 4'(1 << r);
          if ((t - n_gap - n_bounce) > 20 && $urandom % 3 == 0) rows = rows | 4'(1 << extra);
        end else begin
          rows = ($urandom % 10 == 0) ? 4'(1 << r) : 4'b0;
        end
        apply_stimulus(1'b0, rows, col);
        tests++;
        if ({stop, key_valid, key_held, key_code} !== {exp_stop, exp_valid, exp_held, exp_code}) begin
          fails++;
          $display("[TB] FAIL random it %0d t %0d: stop/valid/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                   it, t, stop, key_valid, key_held, key_code, exp_stop, exp_valid, exp_held, exp_code);
        end
      end
      for (int t = 0; t < 20; t++) apply_stimulus(1'b0, 4'b0, 2'd0);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_ghost();
    test_release_bounce();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
